// File: rtl/register_bank_pkg.sv
// Shared datapath definitions for the register bank: index/data widths,
// stack pointer reset, and the swap sequencer state encoding.
package register_bank_pkg;

  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int SP_INDEX  = 29;
  localparam logic [DATA_W-1:0] SP_RESET = 32'd227;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    reg_data_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWAP_RS = 2'd1,
    SWAP_RT = 2'd2
  } xchg_state_t;

  // Power-on content of register idx (only the stack pointer is non-zero).
  function automatic reg_data_t reset_value(input int idx);
    return (idx == SP_INDEX) ? SP_RESET : '0;
  endfunction

endpackage

// File: rtl/register_bank_xchg_sequencer.sv
// XCHG sequencer: latches rs/rt and the original R[rs], then issues the two
// write steps R[rs] <= R[rt] and R[rt] <= saved value.
module register_bank_xchg_sequencer
  import register_bank_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      start,
  input  reg_idx_t  rd_rs,
  input  reg_idx_t  rd_rt,
  input  reg_data_t rs_value,
  input  reg_data_t rt_value,
  output reg_idx_t  rt_sel,
  output logic      busy,
  output reg_data_t saved_value,
  output logic      swap_we,
  output reg_idx_t  swap_idx,
  output reg_data_t swap_data
);

  xchg_state_t state_reg, state_next;
  reg_idx_t    rs_reg, rs_next;
  reg_idx_t    rt_reg, rt_next;
  reg_data_t   temp_reg, temp_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      rs_reg    <= '0;
      rt_reg    <= '0;
      temp_reg  <= '0;
    end else begin
      state_reg <= state_next;
      rs_reg    <= rs_next;
      rt_reg    <= rt_next;
      temp_reg  <= temp_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rs_next    = rs_reg;
    rt_next    = rt_reg;
    temp_next  = temp_reg;
    swap_we    = 1'b0;
    swap_idx   = '0;
    swap_data  = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          rs_next    = rd_rs;
          rt_next    = rd_rt;
          temp_next  = rs_value;
          state_next = SWAP_RS;
        end
      end
      SWAP_RS: begin
        swap_we    = 1'b1;
        swap_idx   = rs_reg;
        swap_data  = rt_value;
        state_next = SWAP_RT;
      end
      SWAP_RT: begin
        swap_we    = 1'b1;
        swap_idx   = rt_reg;
        swap_data  = temp_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // rt is read through a dedicated port so ReadReg2 may change mid-swap.
  assign rt_sel      = rt_reg;
  assign busy        = (state_reg != IDLE);
  assign saved_value = temp_reg;

endmodule

// File: rtl/register_bank.sv
// 32 x 32-bit MIPS register file with two combinational read ports, one
// write port, and a self-sequenced XCHG swap of R[rs] and R[rt].
module register_bank
  import register_bank_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [REG_IDX_W-1:0]  WriteReg,
  input  logic [DATA_W-1:0]     WriteData,
  input  logic [REG_IDX_W-1:0]  ReadReg1,
  input  logic [REG_IDX_W-1:0]  ReadReg2,
  output logic [DATA_W-1:0]     ReadData1,
  output logic [DATA_W-1:0]     ReadData2,
  input  logic                  XCHGStart,
  output logic                  XCHGBusy,
  output logic [DATA_W-1:0]     XCHGRegOut
);

  reg_data_t regs_reg [NREGS];

  reg_idx_t  rt_sel;
  reg_data_t rt_value;
  logic      swap_we;
  reg_idx_t  swap_idx;
  reg_data_t swap_data;
  logic      normal_we;
  logic      wr_en;
  reg_idx_t  wr_idx;
  reg_data_t wr_data;

  register_bank_xchg_sequencer u_seq (
    .clk         (clk),
    .reset       (reset),
    .start       (XCHGStart),
    .rd_rs       (ReadReg1),
    .rd_rt       (ReadReg2),
    .rs_value    (ReadData1),
    .rt_value    (rt_value),
    .rt_sel      (rt_sel),
    .busy        (XCHGBusy),
    .saved_value (XCHGRegOut),
    .swap_we     (swap_we),
    .swap_idx    (swap_idx),
    .swap_data   (swap_data)
  );

  // A swap request in the same cycle as a normal write takes priority.
  assign normal_we = RegWrite && !XCHGBusy && !XCHGStart;
  assign wr_en     = swap_we || normal_we;
  assign wr_idx    = swap_we ? swap_idx  : WriteReg;
  assign wr_data   = swap_we ? swap_data : WriteData;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= reset_value(i);
      end
    end else if (wr_en && (wr_idx != '0)) begin
      regs_reg[wr_idx] <= wr_data;
    end
  end

  // R[0] is never written, so it always reads its reset value of zero.
  assign ReadData1 = regs_reg[ReadReg1];
  assign ReadData2 = regs_reg[ReadReg2];
  assign rt_value  = regs_reg[rt_sel];

endmodule
